// File: rtl/hc165_piso_if.sv
`default_nettype none
// ============================================================================
//  Module   : hc165_piso_if
//  Brief    : Load/shift controls, parallel data and status bus of hc165_piso.
//  Revision : 1.0
// ============================================================================
interface hc165_piso_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             PL_n;
    logic             CE_n;
    logic             DS;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             Q7;
    logic             Q7_n;
    logic [CW-1:0]    CNT;
    logic             BUSY;
    logic             LAST;

    modport master (
        output PL_n, CE_n, DS, D,
        input  Q, Q7, Q7_n, CNT, BUSY, LAST
    );

    modport slave (
        input  PL_n, CE_n, DS, D,
        output Q, Q7, Q7_n, CNT, BUSY, LAST
    );
endinterface
`default_nettype wire

// File: rtl/hc165_piso.sv
`default_nettype none
// ============================================================================
//  Module   : hc165_piso
//  Brief    : 74HC165-style PISO shift register with frame bit counter/flags.
//  Revision : 1.0
// ============================================================================
module hc165_piso #(
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  wire logic      CP,
    input  wire logic      MR_n,
    hc165_piso_if.slave    bus
);
    localparam logic [CW-1:0] C_CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;

    // Priority: reset, then load, then shift; load ignores CE_n entirely.
    always_ff @(posedge CP) begin
        if (!MR_n) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (!bus.PL_n) begin
            r_q   <= bus.D;
            r_cnt <= C_CNT_FULL;
        end else if (!bus.CE_n) begin
            r_q <= {r_q[WIDTH-2:0], bus.DS};
            // Counter saturates at zero so cascade shifting never re-arms BUSY.
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - C_CNT_ONE;
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.Q7   = r_q[WIDTH-1];
    assign bus.Q7_n = ~r_q[WIDTH-1];
    assign bus.CNT  = r_cnt;
    assign bus.BUSY = (r_cnt != '0);
    assign bus.LAST = (r_cnt == C_CNT_ONE);
endmodule
`default_nettype wire

// File: doc/hc165_piso.md
Name: hc165_piso

Overview:
- Synchronous parallel-in/serial-out shift register in the 74HC165 style, extended with a bit counter and status flags.
- Sits directly downstream of the HC161 counter stage. It snapshots the counter word in parallel: D[3:0] from the counter Q, D[4] from TC, remaining bits tied low.
- It then shifts the snapshot out MSB-first on a single serial line.
- Cascadable: DS accepts Q7 of a following stage.

Parameters:
- WIDTH, 8, shift register length in bits; legal range 2..16.
- CW, $clog2(WIDTH+1), width of the bit counter output; derived, not overridden.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- MR_n  input  1  master reset; synchronous, active-low.
- PL_n  input  1  parallel load; synchronous, active-low.
- CE_n  input  1  shift enable; active-low.
- DS  input  1  serial data in, shifted into bit 0.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  shift register contents.
- Q7  output  1  serial out = Q[WIDTH-1].
- Q7_n  output  1  inverted serial out.
- CNT  output  CW  number of loaded bits not yet shifted past Q7.
- BUSY  output  1  high while CNT != 0.
- LAST  output  1  high while CNT == 1 (Q7 carries the final loaded bit).

Behaviour:
- Single clock CP. Reset is synchronous and active-low, sampled on the rising edge of CP. No asynchronous paths.
- Per-edge priority: MR_n=0, then PL_n=0, then CE_n=0, else hold.
- Reset (MR_n=0): Q=0, CNT=0. Therefore Q7=0, Q7_n=1, BUSY=0, LAST=0.
  - Reset overrides a simultaneous load or shift.
  - Reset mid-shift aborts the frame immediately; no partial bits continue.
- Load (MR_n=1, PL_n=0): Q<=D, CNT<=WIDTH, regardless of CE_n.
  - Zero latency to Q7: Q7=D[WIDTH-1] is valid in the cycle after the load edge, before any shift.
- Shift (MR_n=1, PL_n=1, CE_n=0): Q<={Q[WIDTH-2:0], DS}.
  - If CNT>0, CNT<=CNT-1. If CNT==0, CNT stays 0 (saturates, no wrap to max).
  - Shifting with CNT==0 remains legal and keeps moving DS data through (cascade mode).
- Hold (MR_n=1, PL_n=1, CE_n=1): Q and CNT unchanged.
- Combinational outputs, decoded from registers only (no input-to-output combinational path):
  - Q7=Q[WIDTH-1], Q7_n=~Q[WIDTH-1].
  - BUSY=(CNT!=0), LAST=(CNT==1).
- Frame length: after a load, WIDTH bits appear on Q7.
  - Bit k (k=0..WIDTH-1) is valid after k shift edges.
  - LAST is high during bit WIDTH-1.
  - BUSY falls on the WIDTH-th shift edge.
- Load during an active frame restarts the frame: the new D is captured, CNT=WIDTH, and old bits are discarded.
- Load and shift asserted together: load wins; no shift occurs that edge.
- CE_n toggling mid-frame: the frame pauses and resumes. Bit order is preserved and CNT is held while paused.
- All outputs are defined (non-X) from the first edge on which MR_n=0 has been applied.

Test Plan:
- Reset: MR_n=0 for one CP edge with PL_n=0, D=8'hFF -> Q=8'h00, CNT=0, Q7=0, Q7_n=1, BUSY=0, LAST=0 (reset beats load).
- Load/shift frame: WIDTH=8, PL_n=0 one edge with D=8'hA5, then CE_n=0 with DS=0.
  - Q7 sequence across 8 cycles -> 1,0,1,0,0,1,0,1.
  - CNT 8,7,...,1 then 0.
  - LAST high only on the 8th bit; BUSY low after the 8th shift edge; Q=8'h00.
- Counter snapshot: D={3'b000, TC=1, Q=4'b1111}=8'h1F, shift out -> Q7 sequence 0,0,0,1,1,1,1,1.
- Pause and saturate:
  - Load 8'hC3, shift 3 edges, hold CE_n=1 for 5 edges -> Q and CNT=5 unchanged.
  - Resume -> remaining bits 0,0,0,1,1.
  - 3 extra shifts with DS=1 -> CNT stays 0, Q low bits fill with 1s.
- Restart and priority:
  - Load 8'hF0, shift 2 edges, then PL_n=0 and CE_n=0 together with D=8'h0F -> Q=8'h0F, CNT=8, Q7=0.
  - Reset mid-frame after 4 shifts -> Q=0, CNT=0 next edge.
